mult_issue_q: RTL and testbench

MULT_ISSUE_Q -- requirements
Module: mult_issue_q

---
 rtl/mult_issue_q.sv | 140 ++++++++++++++
 tb/tb_mult_issue_q.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_q.sv
// Operand-pair issue queue in front of a multi-cycle multiplier: FIFO of (mcand, mplier), one op in flight, single result slot.
// Optional feature: define MULT_IQ_ZERO_SKIP_EN to bypass the multiplier when either operand is zero.
module mult_issue_q #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_mcand,
    input  logic [63:0]              in_mplier,
    output logic                     mult_start,
    output logic [63:0]              mult_mcand,
    output logic [63:0]              mult_mplier,
    input  logic                     mult_done,
    input  logic [63:0]              mult_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_product,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT      = 3'd2,
        SKIP_WAIT = 3'd3,
        DONE_HOLD = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            first_q;
    logic            start_q, valid_q;
    logic [63:0]     mcand_q, mplier_q, product_q;
    logic [63:0]     mcand_mem  [DEPTH];
    logic [63:0]     mplier_mem [DEPTH];

    logic push, pop, head_zero;

    assign in_ready  = (count_q < (PW+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    // Pop only when the result slot is free: strictly one op in flight.
    assign pop       = (state_q == IDLE) && (count_q != '0) && !valid_q;
    assign head_zero = (mcand_mem[rd_ptr_q] == 64'd0) || (mplier_mem[rd_ptr_q] == 64'd0);
    assign count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    assign mult_start  = start_q;
    assign mult_mcand  = mcand_q;
    assign mult_mplier = mplier_q;
    assign out_valid   = valid_q;
    assign out_product = product_q;
    assign count       = count_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mcand_mem[wr_ptr_q]  <= in_mcand;
            mplier_mem[wr_ptr_q] <= in_mplier;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            first_q   <= 1'b0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
`ifdef MULT_IQ_ZERO_SKIP_EN
                        if (head_zero) begin
                            state_q <= SKIP_WAIT;
                        end else begin
                            mcand_q  <= mcand_mem[rd_ptr_q];
                            mplier_q <= mplier_mem[rd_ptr_q];
                            start_q  <= 1'b1;
                            state_q  <= ISSUE;
                        end
`else
                        mcand_q  <= mcand_mem[rd_ptr_q];
                        mplier_q <= mplier_mem[rd_ptr_q];
                        start_q  <= 1'b1;
                        state_q  <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    first_q <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // First WAIT cycle may still see done from the previous op.
                    first_q <= 1'b0;
                    if (!first_q && mult_done) begin
                        product_q <= mult_product;
                        valid_q   <= 1'b1;
                        state_q   <= DONE_HOLD;
                    end
                end
`ifdef MULT_IQ_ZERO_SKIP_EN
                SKIP_WAIT: begin
                    product_q <= 64'd0;
                    valid_q   <= 1'b1;
                    state_q   <= DONE_HOLD;
                end
`endif
                DONE_HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = head_zero;
endmodule

// File: tb/tb_mult_issue_q.sv
// Directed + random bench for mult_issue_q with a behavioural multiplier (sticky done, 3-cycle latency).
module tb_mult_issue_q;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_mcand = '0, in_mplier = '0;
    logic        mult_start;
    logic [63:0] mult_mcand, mult_mplier;
    logic        mult_done;
    logic [63:0] mult_product;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_product;
    logic [$clog2(DEPTH):0] count;

    mult_issue_q #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mcand(in_mcand), .in_mplier(in_mplier),
        .mult_start(mult_start), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_done(mult_done), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .count(count)
    );

    always #5 clock = ~clock;

    // Multiplier: done stays high until one edge after the next start is seen.
    logic [2:0]  m_cnt;
    logic        m_clr;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt <= '0; m_clr <= 1'b0; mult_done <= 1'b0; mult_product <= '0;
        end else begin
            m_clr <= mult_start;
            if (m_clr) mult_done <= 1'b0;
            if (mult_start) begin
                m_cnt <= 3'd3;
                mult_product <= mult_mcand * mult_mplier;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1'b1;
                if (m_cnt == 3'd1) mult_done <= 1'b1;
            end
        end
    end

    int n_cmp = 0, n_mis = 0;
    int n_start = 0, n_vcyc = 0, hold_err = 0;
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    logic        held = 1'b0;
    logic [63:0] held_prod = '0;
    logic        rnd_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (mult_start) n_start++;
            if (out_valid) n_vcyc++;
            if (out_valid && held && out_product !== held_prod) hold_err++;
            if (out_valid && out_ready) begin
                got.push_back(out_product);
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_prod = out_product;
            end else held = 1'b0;
        end else held = 1'b0;
    end

    always @(posedge clock) if (rnd_en) #1 out_ready = 1'($urandom_range(0, 1));

    task automatic push(input logic [63:0] a, input logic [63:0] b);
        int t = 0;
        @(negedge clock);
        in_valid = 1'b1; in_mcand = a; in_mplier = b;
        while (!in_ready && t < 300) begin @(negedge clock); t++; end
        if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
        exp_q.push_back(a * b);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int lim);
        int t = 0;
        while (got.size() < n && t < lim) begin @(negedge clock); t++; end
        chk("wait_results", 64'(got.size()), 64'(n));
    endtask

    task automatic clear_stats();
        got.delete(); exp_q.delete();
        n_start = 0; n_vcyc = 0;
    endtask

    logic [63:0] t3_exp [6] = '{64'd11, 64'd24, 64'd39, 64'd56, 64'd75, 64'd96};

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_start", 64'(mult_start), 64'd0);
        chk("rst_product", out_product, 64'd0);
        chk("rst_mcand", mult_mcand, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single op
        clear_stats();
        @(posedge clock); #1 out_ready = 1'b1;
        push(64'd2, 64'd3);
        wait_got(1, 50);
        repeat (3) @(negedge clock);
        chk("t1_product", got[0], 64'h6);
        chk("t1_starts", 64'(n_start), 64'd1);
        chk("t1_valid_cycles", 64'(n_vcyc), 64'd1);

        // Back-to-back signed pairs
        clear_stats();
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        push(64'hFFFF_FFFF_FFFF_FFEC, 64'd5);
        wait_got(2, 100);
        chk("t2_res0", got[0], 64'hFFFF_FFFF_FFFF_FFFD);
        chk("t2_res1", got[1], 64'hFFFF_FFFF_FFFF_FF9C);

        // Backpressure fills the queue
        clear_stats();
        @(posedge clock); #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) push(64'(i), 64'(i + 10));
            end
            begin
                int t = 0;
                while (count != DEPTH && t < 100) begin @(negedge clock); t++; end
                chk("t3_full", 64'(count), 64'(DEPTH));
                chk("t3_in_ready_low", 64'(in_ready), 64'd0);
                repeat (30) @(negedge clock);
                chk("t3_one_start", 64'(n_start), 64'd1);
                chk("t3_none_out", 64'(got.size()), 64'd0);
                @(posedge clock); #1 out_ready = 1'b1;
            end
        join
        wait_got(6, 300);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_res%0d", i), got[i], t3_exp[i]);

        // Reset during WAIT with 3 queued
        repeat (5) @(negedge clock);
        clear_stats();
        push(64'd7, 64'd8);
        push(64'd9, 64'd10);
        push(64'd11, 64'd12);
        push(64'd13, 64'd14);
        chk("t4_in_flight", 64'(n_start), 64'd1);
        chk("t4_queued", 64'(count), 64'd3);
        reset = 1'b0;
        #1;
        chk("t4_rst_count", 64'(count), 64'd0);
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_start", 64'(mult_start), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);
        chk("t4_no_stale", 64'(got.size()), 64'd0);
        chk("t4_valid_after", 64'(out_valid), 64'd0);
        chk("t4_count_after", 64'(count), 64'd0);
        chk("t4_no_reissue", 64'(n_start), 64'd1);

        // Zero operand handling
        clear_stats();
        push(64'd0, 64'd7);
        push(64'd4, 64'd5);
        wait_got(2, 100);
        chk("t5_res0", got[0], 64'd0);
        chk("t5_res1", got[1], 64'h14);
`ifdef MULT_IQ_ZERO_SKIP_EN
        chk("t5_starts", 64'(n_start), 64'd1);
`else
        chk("t5_starts", 64'(n_start), 64'd2);
`endif

        // Random pairs with random output stalls
        repeat (3) @(negedge clock);
        clear_stats();
        hold_err = 0;
        rnd_en = 1'b1;
        for (int i = 0; i < 60; i++) push({$urandom, $urandom}, {$urandom, $urandom});
        wait_got(60, 5000);
        rnd_en = 1'b0;
        for (int i = 0; i < 60 && i < got.size(); i++)
            chk($sformatf("t6_res%0d", i), got[i], exp_q[i]);
        repeat (20) @(negedge clock);
        chk("t6_no_dup", 64'(got.size()), 64'd60);
        chk("t6_hold_stable", 64'(hold_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
